// File: rtl/shifter_lfsr_checker.sv
// Receive-side PRBS checker for an XNOR Fibonacci LFSR generator.
// Seeds a local LFSR from the incoming stream, synchronises to it, then
// flags and counts bit errors while locked and drops lock when too many
// errors land inside one monitoring window.
module shifter_lfsr_checker #(
  parameter int N           = 5,
  parameter int LOCK_CNT    = 16,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CW          = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_clear,
  input  logic [N-1:0]  i_taps,
  input  logic          i_rx_valid,
  input  logic          i_rx_bit,
  output logic          o_locked,
  output logic          o_error,
  output logic          o_lock_loss,
  output logic [CW-1:0] o_err_count,
  output logic [CW-1:0] o_bit_count,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    SYNC   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int FW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  // WIN is a power of two (>= 2), so win_pos wraps naturally.
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  state_t          state,     state_n;
  logic [N-1:0]    chk,       chk_n;
  logic [FW-1:0]   fill,      fill_n;
  logic [MW-1:0]   match_cnt, match_n;
  logic [WW-1:0]   win_pos,   win_pos_n;
  logic [EW-1:0]   win_err,   win_err_n;
  logic [CW-1:0]   err_count, err_n;
  logic [CW-1:0]   bit_count, bit_n;
  logic            error_q,   error_n;
  logic            loss_q,    loss_n;

  logic            predict;
  logic            mismatch;
  logic [EW-1:0]   win_err_acc;

  // Next-state, shift register, counters and pulse outputs.
  always_comb begin
    state_n   = state;
    chk_n     = chk;
    fill_n    = fill;
    match_n   = match_cnt;
    win_pos_n = win_pos;
    win_err_n = win_err;
    err_n     = err_count;
    bit_n     = bit_count;
    error_n   = 1'b0;
    loss_n    = 1'b0;

    predict  = ~^(chk & i_taps);
    mismatch = (predict != i_rx_bit);
    // The beat that wraps the window position opens the new window, so its
    // own error is counted against the fresh window.
    win_err_acc = ((win_pos == '1) ? '0 : win_err) + EW'(mismatch);

    if (!i_enable) begin
      state_n   = IDLE;
      fill_n    = '0;
      match_n   = '0;
      win_pos_n = '0;
      win_err_n = '0;
    end else begin
      unique case (state)
        IDLE: state_n = SEED;

        SEED: begin
          if (i_rx_valid) begin
            chk_n = {chk[N-2:0], i_rx_bit};
            if (fill == FW'(N - 1)) begin
              fill_n  = '0;
              state_n = SYNC;
            end else begin
              fill_n = fill + 1'b1;
            end
          end
        end

        SYNC: begin
          if (i_rx_valid) begin
            chk_n = {chk[N-2:0], i_rx_bit};
            // All-ones is the XNOR lock-up state and never counts as a match.
            if (mismatch || (&chk)) begin
              match_n = '0;
            end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
              match_n   = '0;
              win_pos_n = '0;
              win_err_n = '0;
              state_n   = LOCKED;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end
        end

        LOCKED: begin
          if (i_rx_valid) begin
            // Shift the prediction so a corrupted bit cannot derail the LFSR.
            chk_n     = {chk[N-2:0], predict};
            bit_n     = (bit_count == '1) ? bit_count : bit_count + 1'b1;
            win_pos_n = win_pos + 1'b1;
            win_err_n = win_err_acc;
            if (mismatch) begin
              error_n = 1'b1;
              err_n   = (err_count == '1) ? err_count : err_count + 1'b1;
            end
            if (win_err_acc == EW'(LOSS_THRESH)) begin
              state_n   = SYNC;
              loss_n    = 1'b1;
              match_n   = '0;
              win_pos_n = '0;
              win_err_n = '0;
            end
          end
        end
      endcase
    end

    if (i_clear) begin
      err_n = '0;
      bit_n = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      chk       <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_pos   <= '0;
      win_err   <= '0;
      err_count <= '0;
      bit_count <= '0;
      error_q   <= 1'b0;
      loss_q    <= 1'b0;
    end else begin
      state     <= state_n;
      chk       <= chk_n;
      fill      <= fill_n;
      match_cnt <= match_n;
      win_pos   <= win_pos_n;
      win_err   <= win_err_n;
      err_count <= err_n;
      bit_count <= bit_n;
      error_q   <= error_n;
      loss_q    <= loss_n;
    end
  end

  assign o_locked    = (state == LOCKED);
  assign o_error     = error_q;
  assign o_lock_loss = loss_q;
  assign o_err_count = err_count;
  assign o_bit_count = bit_count;
  assign o_state     = state;

endmodule

// File: tb/tb_shifter_lfsr_checker.sv
// Testbench for shifter_lfsr_checker: randomized and directed PRBS streams
// checked cycle by cycle against a beat-level reference model.
module tb_shifter_lfsr_checker;

  localparam int N           = 5;
  localparam int LOCK_CNT    = 16;
  localparam int WIN         = 64;
  localparam int LOSS_THRESH = 8;
  localparam int CW          = 8;
  localparam int TAPS        = 20;   // 5'b10100
  localparam int MASK        = 31;
  localparam int CMAX        = 255;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          clr   = 1'b0;
  logic          vld   = 1'b0;
  logic          rxb   = 1'b0;
  logic [N-1:0]  taps  = 5'b10100;
  logic          o_locked, o_error, o_lock_loss;
  logic [CW-1:0] o_err_count, o_bit_count;
  logic [1:0]    o_state;

  shifter_lfsr_checker #(
    .N(N), .LOCK_CNT(LOCK_CNT), .WIN(WIN), .LOSS_THRESH(LOSS_THRESH), .CW(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_clear(clr),
    .i_taps(taps), .i_rx_valid(vld), .i_rx_bit(rxb),
    .o_locked(o_locked), .o_error(o_error), .o_lock_loss(o_lock_loss),
    .o_err_count(o_err_count), .o_bit_count(o_bit_count), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: tracks the checker per received beat in plain integers.
  int m_state, m_chk, m_fill, m_match, m_lk, m_wid, m_wcnt, m_errs, m_bits;
  bit e_err, e_loss;

  function automatic bit xnor_fb(input int v);
    return ($countones(v & TAPS) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_chk = 0; m_fill = 0; m_match = 0;
    m_lk = 0; m_wid = 0; m_wcnt = 0; m_errs = 0; m_bits = 0;
    e_err = 0; e_loss = 0;
  endtask

  task automatic model_step(input bit men, input bit mclr, input bit mv, input bit mb);
    bit p, mis;
    int wid;
    e_err = 0; e_loss = 0;
    if (!men) begin
      m_state = 0; m_fill = 0; m_match = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (mv) begin
      p = xnor_fb(m_chk);
      if (m_state == 1) begin
        m_chk = ((m_chk << 1) | int'(mb)) & MASK;
        m_fill++;
        if (m_fill == N) begin m_fill = 0; m_state = 2; end
      end else if (m_state == 2) begin
        mis   = (p != mb) || (m_chk == MASK);
        m_chk = ((m_chk << 1) | int'(mb)) & MASK;
        m_match = mis ? 0 : m_match + 1;
        if (m_match == LOCK_CNT) begin
          m_state = 3; m_match = 0; m_lk = 0; m_wid = 0; m_wcnt = 0;
        end
      end else begin
        mis    = (p != mb);
        m_chk  = ((m_chk << 1) | int'(p)) & MASK;
        m_bits = (m_bits < CMAX) ? m_bits + 1 : CMAX;
        if (mis) begin
          e_err  = 1;
          m_errs = (m_errs < CMAX) ? m_errs + 1 : CMAX;
        end
        // Window index of beat k since lock is (k+1)/WIN.
        wid = (m_lk + 1) / WIN;
        if (wid != m_wid) begin m_wid = wid; m_wcnt = 0; end
        m_wcnt += int'(mis);
        m_lk++;
        if (m_wcnt == LOSS_THRESH) begin
          m_state = 2; e_loss = 1; m_match = 0;
        end
      end
    end
    if (mclr) begin m_errs = 0; m_bits = 0; end
  endtask

  task automatic compare_all();
    check("state",     32'(o_state),     32'(m_state));
    check("locked",    32'(o_locked),    32'(m_state == 3));
    check("error",     32'(o_error),     32'(e_err));
    check("lock_loss", 32'(o_lock_loss), 32'(e_loss));
    check("err_count", 32'(o_err_count), 32'(m_errs));
    check("bit_count", 32'(o_bit_count), 32'(m_bits));
  endtask

  task automatic step(input bit sen, input bit sclr, input bit sv, input bit sb);
    en = sen; clr = sclr; vld = sv; rxb = sb;
    @(posedge clk);
    model_step(sen, sclr, sv, sb);
    #1;
    compare_all();
  endtask

  // Transmit-side generator.
  int g;
  function automatic bit gen_bit();
    bit nb;
    nb = xnor_fb(g);
    g  = ((g << 1) | int'(nb)) & MASK;
    return nb;
  endfunction

  int beat_no, lock_at;
  bit was_locked;

  task automatic beat(input bit inv, input bit bclr, input bit gaps);
    bit b;
    if (gaps)
      for (int k = 0; k < 20 && $urandom_range(1) == 0; k++)
        step(1'b1, 1'b0, 1'b0, 1'($urandom_range(1)));
    b = gen_bit() ^ inv;
    step(1'b1, bclr, 1'b1, b);
    beat_no++;
    if (o_locked && !was_locked && lock_at < 0) lock_at = beat_no;
    was_locked = o_locked;
  endtask

  task automatic start_run();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    g = 0; beat_no = 0; lock_at = -1; was_locked = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int guard, relock;
    bit ever_locked;
    model_reset();
    #12;
    check("rst_state",  32'(o_state), 0);
    check("rst_locked", 32'(o_locked), 0);
    check("rst_errcnt", 32'(o_err_count), 0);
    check("rst_bitcnt", 32'(o_bit_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream from seed 0: lock after N seed bits plus LOCK_CNT matches.
    start_run();
    for (int i = 0; i < 100; i++) beat(1'b0, 1'b0, 1'b0);
    check("lock_beat", 32'(lock_at), 21);
    check("clean_err", 32'(o_err_count), 0);
    check("clean_bits", 32'(o_bit_count), 79);

    // Single inverted bit while locked.
    beat(1'b1, 1'b0, 1'b0);
    check("single_error", 32'(o_error), 1);
    check("single_errcnt", 32'(o_err_count), 1);
    check("single_locked", 32'(o_locked), 1);
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 1'b0, 1'b0);
      check("after_error", 32'(o_error), 0);
    end

    // Eight errors inside one window force loss of lock, then relock.
    guard = 0;
    do begin
      beat(1'b0, 1'b0, 1'b0);
      guard++;
    end while (!(guard >= 64 && ((m_lk + 1) % WIN) <= WIN - 8) && guard < 200);
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 1'b0, 1'b0);
      if (i == 6) check("loss_early", 32'(o_lock_loss), 0);
    end
    check("loss_pulse", 32'(o_lock_loss), 1);
    check("loss_state", 32'(o_state), 2);
    relock = -1;
    for (int i = 1; i <= 40; i++) begin
      beat(1'b0, 1'b0, 1'b0);
      if (o_locked && relock < 0) relock = i;
    end
    check("relock_beats", 32'(relock), 16);

    // Constant ones (lock-up pattern) never locks.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    start_run();
    ever_locked = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      if (o_locked) ever_locked = 1;
    end
    check("lockup_never", 32'(ever_locked), 0);
    check("lockup_errcnt", 32'(o_err_count), 0);
    check("lockup_state", 32'(o_state), 2);

    // Clear coincident with an error beat, then disable while locked.
    start_run();
    for (int i = 0; i < 30; i++) beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    check("clr_err_pulse", 32'(o_error), 1);
    check("clr_errcnt", 32'(o_err_count), 0);
    check("clr_bitcnt", 32'(o_bit_count), 0);
    for (int i = 0; i < 4; i++) beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("dis_state", 32'(o_state), 0);
    check("dis_errcnt", 32'(o_err_count), 1);
    check("dis_bitcnt", 32'(o_bit_count), 5);

    // Gap-free versus 50% gapped stream give the same lock beat and counts.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    start_run();
    for (int i = 0; i < 100; i++) beat(1'b0, 1'b0, 1'b0);
    check("nogap_lock", 32'(lock_at), 21);
    check("nogap_bits", 32'(o_bit_count), 79);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    start_run();
    for (int i = 0; i < 100; i++) beat(1'b0, 1'b0, 1'b1);
    check("gap_lock", 32'(lock_at), 21);
    check("gap_bits", 32'(o_bit_count), 79);
    check("gap_err", 32'(o_err_count), 0);

    // Random errors and gaps, then a long clean run to saturate bit_count.
    for (int i = 0; i < 400; i++) beat(1'($urandom_range(24) == 0), 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) beat(1'b0, 1'b0, 1'b0);
    check("sat_bits", 32'(o_bit_count), CMAX);
    check("sat_locked", 32'(o_locked), 1);

    // Asynchronous reset mid-lock.
    rst_n = 1'b0;
    #2;
    check("arst_state", 32'(o_state), 0);
    check("arst_locked", 32'(o_locked), 0);
    check("arst_errcnt", 32'(o_err_count), 0);
    check("arst_bitcnt", 32'(o_bit_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
